// File: rtl/uart_pkg.sv
// uart_pkg: shared feeder FSM states and default FIFO geometry
package uart_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF = 4;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} feed_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: byte FIFO with occupancy count and registered full/empty flags
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q, count_d;
  logic full_q, empty_q, do_push, do_pop;
  assign do_push = push_i && !full_q;
  assign do_pop = pop_i && !empty_q;
  assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout_o = mem_q[rptr_q];
  assign full_o = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;
  // storage array needs no reset; only accepted pushes write it
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end
  // pointers wrap naturally; flags are registered from the next count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q <= do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_q <= do_pop ? rptr_q + AW'(1) : rptr_q;
      count_q <= count_d;
      full_q <= count_d == (AW+1)'(DEPTH);
      empty_q <= count_d == '0;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serializer; UART_TX_FIFO_STATUS_EN enables overflow/level
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_ready,
  output logic          overflow,
  output logic [AW:0]   level
);
  feed_state_e state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d, head;
  logic tx_start_q, tx_start_d, first_q, first_d, pop, full_w, empty_w;
  logic [AW:0] count_w;
  sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(wr_en),
    .pop_i(pop),
    .din_i(wr_data),
    .dout_o(head),
    .full_o(full_w),
    .empty_o(empty_w),
    .count_o(count_w)
  );
  assign full = full_w;
  assign empty = empty_w;
  assign tx_data = tx_data_q;
  assign tx_start = tx_start_q;
  // feeder: pop on ready, pulse start for one cycle, then wait out the frame
  always_comb begin
    state_d = state_q;
    tx_data_d = tx_data_q;
    tx_start_d = 1'b0;
    first_d = 1'b0;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty_w && tx_ready) begin
        pop = 1'b1;
        tx_data_d = head;
        tx_start_d = 1'b1;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = BUSY;
        first_d = 1'b1;
      end
      BUSY: state_d = (!first_q && tx_ready) ? IDLE : BUSY;
      default: state_d = IDLE;
    endcase
  end
  // feeder state and launch registers; first_q masks ready in the first BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_data_q <= 8'h00;
      tx_start_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= tx_start_d;
      first_q <= first_d;
    end
  end
`ifdef UART_TX_FIFO_STATUS_EN
  logic overflow_q;
  // sticky flag for any write refused because the FIFO was full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else if (wr_en && full_w) overflow_q <= 1'b1;
  end
  assign overflow = overflow_q;
  assign level = count_w;
`else
  logic unused_count;
  assign unused_count = ^count_w;
  assign overflow = 1'b0;
  assign level = '0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW = 4;
`ifdef UART_TX_FIFO_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00, tx_data;
  logic full, empty, tx_start, tx_ready, overflow;
  logic [AW:0] level;
  logic use_model = 1'b0, rdy_force = 1'b0, ready_m;
  int ser_cnt = 0;
  int checks = 0, errors = 0;
  logic [7:0] sb [$];
  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .empty(empty),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_ready(tx_ready),
    .overflow(overflow),
    .level(level)
  );
  always #5 clk = ~clk;
  // serializer model: 10 bits x CD_MAX=4 cycles per frame, ready on last cycle
  assign ready_m = (ser_cnt == 0 && !tx_start) || ser_cnt == 1;
  assign tx_ready = use_model ? ready_m : rdy_force;
  always @(posedge clk) begin
    if (tx_start) ser_cnt <= 40;
    else if (ser_cnt > 0) ser_cnt <= ser_cnt - 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic write_byte(input logic [7:0] d);
    wr_data = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic wait_launch(input string tag);
    int n = 0;
    logic [7:0] exp;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 200);
    chk({tag, "_launch"}, tx_start, 1);
    if (tx_start) begin
      chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk({tag, "_data"}, tx_data, exp);
      end
    end
  endtask
  initial begin
    logic [7:0] exp;
    int launches;
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_ovf", overflow, 0);
    chk("rst_level", level, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rdy_force = 1'b1;
    sb.push_back(8'h41);
    write_byte(8'h41);
    chk("t1_no_start_early", tx_start, 0);
    @(negedge clk);
    chk("t1_start", tx_start, 1);
    exp = sb.pop_front();
    chk("t1_data", tx_data, exp);
    @(negedge clk);
    chk("t1_width", tx_start, 0);
    chk("t1_hold", tx_data, 8'h41);
    repeat (4) @(negedge clk);
    chk("t1_empty", empty, 1);
    use_model = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'h31 + 8'(i));
      write_byte(8'h31 + 8'(i));
    end
    chk("t2_level3", level, STAT ? 3 : 0);
    for (int k = 0; k < 3; k++) wait_launch("t2");
    chk("t2_empty", empty, 1);
    use_model = 1'b0;
    rdy_force = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      sb.push_back(8'h50 + 8'(i));
      write_byte(8'h50 + 8'(i));
    end
    chk("t3_not_full15", full, 0);
    sb.push_back(8'h5f);
    write_byte(8'h5f);
    chk("t3_full16", full, 1);
    chk("t3_level16", level, STAT ? 16 : 0);
    chk("t3_ovf_before", overflow, 0);
    write_byte(8'hdd);
    chk("t3_full17", full, 1);
    chk("t3_ovf", overflow, STAT ? 1 : 0);
    chk("t3_level17", level, STAT ? 16 : 0);
    chk("t3_no_start", tx_start, 0);
    rdy_force = 1'b1;
    @(negedge clk);
    write_byte(8'hee);
    chk("t4_level15", level, STAT ? 15 : 0);
    chk("t4_full", full, 0);
    chk("t4_start", tx_start, 1);
    exp = sb.pop_front();
    chk("t4_data", tx_data, exp);
    chk("t4_ovf", overflow, STAT ? 1 : 0);
    for (int k = 0; k < 10; k++) wait_launch("t5_drain");
    rdy_force = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_start", tx_start, 0);
    chk("t5_rst_empty", empty, 1);
    chk("t5_rst_full", full, 0);
    chk("t5_rst_data", tx_data, 8'h00);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    rdy_force = 1'b1;
    launches = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_start) launches++;
    end
    chk("t5_no_launch", launches, 0);
    chk("t5_still_empty", empty, 1);
    sb.push_back(8'h7a);
    write_byte(8'h7a);
    wait_launch("t5_new");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 4, pointer width (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all logic is posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wr_data  input  8  byte to enqueue.
REQ-006 SHALL have port wr_en  input  1  enqueue strobe, one byte per high cycle.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port tx_data  output  8  byte to the downstream serializer's tbus input.
REQ-010 SHALL have port tx_start  output  1  one-cycle launch pulse to the serializer's start input.
REQ-011 SHALL have port tx_ready  input  1  serializer ready (idle with start low, or last-bit cycle).
REQ-012 SHALL have port overflow  output  1  sticky dropped-write flag.
REQ-013 SHALL have port level  output  AW+1  current occupancy.

Function
REQ-014 SHALL, when wr_en=1 and full=0, store wr_data at the write pointer and increment the pointer modulo DEPTH.
REQ-015 SHALL drop wr_en=1 when full=1, even if a pop occurs in the same cycle; stored data SHALL be unchanged.
REQ-016 SHALL register full and empty from an occupancy count; a push with simultaneous pop SHALL leave the count unchanged.
REQ-017 SHALL implement feeder FSM states IDLE, LAUNCH, BUSY.
REQ-018 SHALL, in IDLE with empty=0 and tx_ready=1, pop the head byte into tx_data, set tx_start=1 next cycle, and go to LAUNCH.
REQ-019 SHALL, in LAUNCH, hold tx_data stable, drive tx_start=0 on the next edge, and go to BUSY.
REQ-020 SHALL, in BUSY, wait for tx_ready=1 and then return to IDLE; tx_ready in the first BUSY cycle SHALL be ignored.
REQ-021 SHALL have tx_start high for exactly one cycle per byte, and no new launch before BUSY has seen tx_ready.
REQ-022 SHALL change tx_data only on a pop; it holds the last byte otherwise.
REQ-023 SHALL have a latency from a write into an empty FIFO (serializer idle) to tx_start=1 of 2 cycles.
REQ-024 SHALL send bytes in write order with no loss unless dropped under REQ-015.
REQ-025 SHALL keep pointers AW bits wide with natural wrap and the count AW+1 bits wide.

Reset
REQ-026 SHALL, on rst_n=0, immediately clear pointers and count and set empty=1, full=0, tx_start=0, tx_data=8'h00, overflow=0, FSM=IDLE.
REQ-027 SHALL discard queued bytes on reset mid-operation; a byte already launched downstream SHALL complete on its own, and the FSM SHALL wait in IDLE for tx_ready.

Configuration
REQ-028 SHALL, with UART_TX_FIFO_STATUS_EN defined, set overflow on any dropped write (cleared only by reset) and drive level with the occupancy.
REQ-029 SHALL, without UART_TX_FIFO_STATUS_EN, tie overflow and level to 0 and leave the rest of the behaviour identical.

Structure
REQ-030 SHALL place the FSM state enum (IDLE/LAUNCH/BUSY) and the default DEPTH/AW constants in shared package uart_pkg.
REQ-031 SHALL implement storage as sub-module sync_fifo (push/pop, full/empty/count) instantiated by uart_tx_fifo, which holds the feeder FSM.

Verification
REQ-032 SHALL cover: reset, write 8'h41 with tx_ready=1 -> tx_start pulses 2 cycles later with tx_data=8'h41, width 1 cycle.
REQ-033 SHALL cover: write 8'h31,8'h32,8'h33 back-to-back with the serializer model (CD_MAX=4) -> 3 frames in order 31,32,33, and empty=1 after the third pop.
REQ-034 SHALL cover: 17 writes with tx_ready=0 and DEPTH=16 -> full=1 after 16, 17th dropped, overflow=1 and level=16 (STATUS_EN).
REQ-035 SHALL cover: push while full in the same cycle as a pop -> push dropped, level=15 after the cycle.
REQ-036 SHALL cover: rst_n low for 1 cycle during BUSY with 5 queued bytes -> tx_start=0, empty=1, and no further launches until new writes.
REQ-037 SHALL cover: build without UART_TX_FIFO_STATUS_EN and repeat the REQ-034 scenario -> overflow=0 and level=0 throughout, all other outputs matching.
